fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_hold_buf.sv | 39 +++
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants and the fetch FSM state type.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INST_W  = 16;
    localparam int PC_STEP = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid register that parks a fetched {inst, pc2} pair while the
// downstream stage is stalled.
module fetch_hold_buf #(
    parameter int PC_W   = cpu_pkg::PC_W,
    parameter int INST_W = cpu_pkg::INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc2_in,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc2,
    output logic              valid
);

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst  <= {INST_W{1'b0}};
            pc2   <= {PC_W{1'b0}};
            valid <= 1'b0;
        end else if (clear) begin
            inst  <= {INST_W{1'b0}};
            pc2   <= {PC_W{1'b0}};
            valid <= 1'b0;
        end else if (load) begin
            inst  <= inst_in;
            pc2   <= pc2_in;
            valid <= 1'b1;
        end else begin
            inst  <= inst;
            pc2   <= pc2;
            valid <= valid;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, stall hold
// buffer and branch redirect. Optional wait counter under FETCH_WAIT_CNT_EN.
module fetch_unit #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              INST_W   = cpu_pkg::INST_W,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [INST_W-1:0] imem_rdata,
`ifdef FETCH_WAIT_CNT_EN
    output logic [15:0]       wait_cycles,
`endif
    output logic [PC_W-1:0]   PC2_out,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid
);

    import cpu_pkg::*;

    localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-1){1'b1}}, 1'b0};

    fetch_state_t      state_r, state_s;
    logic [PC_W-1:0]   pc_r, pc_s, req_addr_r, req_addr_s, pc2_s;
    logic [PC_W-1:0]   target_s, next_addr_s, buf_pc2_s;
    logic [INST_W-1:0] inst_s, buf_inst_s;
    logic              valid_s, buf_load_s, buf_clear_s, buf_valid_s;

    assign target_s    = redirect_pc & ALIGN_MASK;
    assign next_addr_s = req_addr_r + STEP;
    assign imem_addr   = req_addr_r;

    fetch_hold_buf #(.PC_W(PC_W), .INST_W(INST_W)) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load_s),
        .clear   (buf_clear_s),
        .inst_in (imem_rdata),
        .pc2_in  (next_addr_s),
        .inst    (buf_inst_s),
        .pc2     (buf_pc2_s),
        .valid   (buf_valid_s)
    );

    // Next-state, PC and fetch-output decisions.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        req_addr_s  = req_addr_r;
        pc2_s       = PC2_out;
        inst_s      = inst_out;
        valid_s     = inst_valid;
        buf_load_s  = 1'b0;
        buf_clear_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (redirect) begin
                    pc_s       = target_s;
                    req_addr_s = target_s;
                end else begin
                    req_addr_s = pc_r;
                end
                state_s = REQ;
            end
            REQ: begin
                if (imem_valid) begin
                    if (redirect) begin
                        pc_s       = target_s;
                        req_addr_s = target_s;
                        valid_s    = 1'b0;
                    end else if (stall) begin
                        buf_load_s = 1'b1;
                        pc_s       = next_addr_s;
                        state_s    = HOLD;
                    end else begin
                        inst_s     = imem_rdata;
                        pc2_s      = next_addr_s;
                        valid_s    = 1'b1;
                        pc_s       = next_addr_s;
                        req_addr_s = next_addr_s;
                    end
                end else begin
                    if (redirect) begin
                        pc_s    = target_s;
                        valid_s = 1'b0;
                        state_s = DROP;
                    end else if (stall) begin
                        valid_s = inst_valid;
                    end else begin
                        valid_s = 1'b0;
                    end
                end
            end
            DROP: begin
                // The stale response still has to be consumed at the old address.
                if (redirect) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_valid) begin
                    req_addr_s = pc_s;
                    state_s    = REQ;
                end else begin
                    state_s = DROP;
                end
            end
            HOLD: begin
                if (redirect) begin
                    buf_clear_s = 1'b1;
                    valid_s     = 1'b0;
                    pc_s        = target_s;
                    req_addr_s  = target_s;
                    state_s     = REQ;
                end else if (!stall) begin
                    inst_s      = buf_inst_s;
                    pc2_s       = buf_pc2_s;
                    valid_s     = buf_valid_s;
                    buf_clear_s = 1'b1;
                    req_addr_s  = pc_r;
                    state_s     = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, PC and registered fetch outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            req_addr_r <= RESET_PC;
            PC2_out    <= {PC_W{1'b0}};
            inst_out   <= {INST_W{1'b0}};
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            req_addr_r <= req_addr_s;
            PC2_out    <= pc2_s;
            inst_out   <= inst_s;
            inst_valid <= valid_s;
            imem_req   <= (state_s == REQ) || (state_s == DROP);
        end
    end

`ifdef FETCH_WAIT_CNT_EN
    // Saturating count of request cycles without a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cycles <= 16'h0000;
        end else if (imem_req && !imem_valid && (wait_cycles != 16'hFFFF)) begin
            wait_cycles <= wait_cycles + 16'd1;
        end else begin
            wait_cycles <= wait_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal pins,
// then randomized stall/redirect/latency/reset traffic against a fetch model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, imem_req, imem_valid, inst_valid;
    logic [7:0]  redirect_pc, imem_addr, PC2_out;
    logic [15:0] imem_rdata, inst_out;
`ifdef FETCH_WAIT_CNT_EN
    logic [15:0] wait_cycles;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
`ifdef FETCH_WAIT_CNT_EN
        .wait_cycles (wait_cycles),
`endif
        .PC2_out     (PC2_out),
        .inst_out    (inst_out),
        .inst_valid  (inst_valid)
    );

    typedef struct packed {
        logic [15:0] inst;
        logic [7:0]  pc2;
    } entry_t;

    int checks = 0;
    int errors = 0;

    // Fetch model: what is outstanding, what is parked, what the stage shows.
    logic        m_idle = 1'b1, m_req = 1'b0, m_stale = 1'b0, m_val = 1'b0;
    logic [7:0]  m_pc = 8'h00, m_addr = 8'h00, m_pc2 = 8'h00;
    logic [15:0] m_inst = 16'h0000, m_wait = 16'h0000;
    entry_t      parked[$];
    int          wcnt = 0;
    int          lat = 1;

    logic        s_rst = 1'b1, s_stall = 1'b0, s_redir = 1'b0;
    logic [7:0]  s_rpc = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req) chk("imem_addr", 32'(imem_addr), 32'(m_addr));
        chk("inst_valid", 32'(inst_valid), 32'(m_val));
        chk("PC2_out", 32'(PC2_out), 32'(m_pc2));
        chk("inst_out", 32'(inst_out), 32'(m_inst));
`ifdef FETCH_WAIT_CNT_EN
        chk("wait_cycles", 32'(wait_cycles), 32'(m_wait));
`endif
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic tick();
        logic       resp;
        logic [7:0] tgt;
        entry_t     e;
        resp        = m_req && (wcnt >= lat - 1);
        rst         = s_rst;
        stall       = s_stall;
        redirect    = s_redir;
        redirect_pc = s_rpc;
        imem_valid  = m_req ? resp : ($urandom_range(0, 3) == 0);
        imem_rdata  = 16'hA000 + {8'h00, m_addr};
        tgt         = s_rpc & 8'hFE;
        if (s_rst) begin
            m_idle = 1'b1; m_req = 1'b0; m_stale = 1'b0; m_val = 1'b0;
            m_pc = 8'h00; m_addr = 8'h00; m_pc2 = 8'h00; m_inst = 16'h0000;
            m_wait = 16'h0000; wcnt = 0;
            parked.delete();
        end else begin
            if (m_req && !resp && m_wait != 16'hFFFF) m_wait = m_wait + 16'd1;
            if (m_req) wcnt = resp ? 0 : wcnt + 1;
            if (m_idle) begin
                m_idle = 1'b0;
                m_req  = 1'b1;
                if (s_redir) m_pc = tgt;
                m_addr = m_pc;
            end else if (parked.size() > 0) begin
                if (s_redir) begin
                    parked.delete();
                    m_val = 1'b0; m_pc = tgt; m_addr = tgt; m_req = 1'b1;
                end else if (!s_stall) begin
                    e = parked.pop_front();
                    m_inst = e.inst; m_pc2 = e.pc2; m_val = 1'b1;
                    m_addr = m_pc; m_req = 1'b1;
                end
            end else if (m_stale) begin
                if (s_redir) m_pc = tgt;
                if (resp) begin
                    m_stale = 1'b0;
                    m_addr  = m_pc;
                end
            end else if (resp) begin
                if (s_redir) begin
                    m_pc = tgt; m_addr = tgt; m_val = 1'b0;
                end else if (s_stall) begin
                    parked.push_back('{inst: 16'hA000 + {8'h00, m_addr}, pc2: m_addr + 8'd2});
                    m_pc  = m_addr + 8'd2;
                    m_req = 1'b0;
                end else begin
                    m_inst = 16'hA000 + {8'h00, m_addr};
                    m_pc2  = m_addr + 8'd2;
                    m_val  = 1'b1;
                    m_addr = m_addr + 8'd2;
                    m_pc   = m_addr;
                end
            end else if (s_redir) begin
                m_pc = tgt; m_val = 1'b0; m_stale = 1'b1;
            end else if (!s_stall) begin
                m_val = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_in(input logic r, input logic st, input logic rd, input logic [7:0] rp);
        s_rst = r; s_stall = st; s_redir = rd; s_rpc = rp;
    endtask

    initial begin
        // Reset and zero-wait streaming.
        lat = 1;
        set_in(1'b1, 1'b0, 1'b0, 8'h00); tick();
        chk("rst_pc2", 32'(PC2_out), 32'h00);
        chk("rst_req", 32'(imem_req), 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("first_addr", 32'(imem_addr), 32'h00);
        tick();
        chk("zw_pc2", 32'(PC2_out), 32'h02);
        chk("zw_inst", 32'(inst_out), 32'hA000);
        chk("zw_addr", 32'(imem_addr), 32'h02);
        tick();
        // Three-cycle latency at 8'h04.
        lat = 3;
        tick();
        chk("lat_bubble", 32'(inst_valid), 32'h0);
        chk("lat_addr", 32'(imem_addr), 32'h04);
        tick();
        tick();
        chk("lat_pc2", 32'(PC2_out), 32'h06);
        chk("lat_valid", 32'(inst_valid), 32'h1);
`ifdef FETCH_WAIT_CNT_EN
        chk("lat_wait", 32'(wait_cycles), 32'h2);
`endif
        // Stall as a response arrives, then release.
        lat = 1;
        tick();
        set_in(1'b0, 1'b1, 1'b0, 8'h00); tick();
        chk("hold_pc2", 32'(PC2_out), 32'h08);
        chk("hold_req", 32'(imem_req), 32'h0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("rel_pc2", 32'(PC2_out), 32'h0A);
        chk("rel_addr", 32'(imem_addr), 32'h0A);
        // Redirect to an odd target while a request waits.
        lat = 3;
        set_in(1'b0, 1'b0, 1'b1, 8'h41); tick();
        chk("drop_addr", 32'(imem_addr), 32'h0A);
        chk("drop_valid", 32'(inst_valid), 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 8'h00); tick();
        tick();
        chk("drop_next", 32'(imem_addr), 32'h40);
        lat = 1;
        tick();
        chk("tgt_pc2", 32'(PC2_out), 32'h42);
        chk("tgt_inst", 32'(inst_out), 32'hA040);
        // Redirect coincident with a response, then redirect during HOLD.
        set_in(1'b0, 1'b0, 1'b1, 8'h80); tick();
        chk("coinc_addr", 32'(imem_addr), 32'h80);
        chk("coinc_valid", 32'(inst_valid), 32'h0);
        set_in(1'b0, 1'b1, 1'b0, 8'h00); tick();
        set_in(1'b0, 1'b1, 1'b1, 8'hC5); tick();
        chk("hold_redir", 32'(imem_addr), 32'hC4);
        set_in(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("after_hold", 32'(PC2_out), 32'hC6);
        // Wrap from 8'hFE.
        set_in(1'b0, 1'b0, 1'b1, 8'hFF); tick();
        set_in(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("wrap_pc2", 32'(PC2_out), 32'h00);
        chk("wrap_addr", 32'(imem_addr), 32'h00);
        // Reset with a response arriving in the same cycle.
        lat = 2;
        tick();
        set_in(1'b1, 1'b0, 1'b0, 8'h00); tick();
        chk("mid_rst_valid", 32'(inst_valid), 32'h0);
        chk("mid_rst_inst", 32'(inst_out), 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("restart_addr", 32'(imem_addr), 32'h00);
        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if (wcnt == 0) lat = $urandom_range(1, 4);
            s_rst   = ($urandom_range(0, 199) == 0);
            s_stall = ($urandom_range(0, 9) < 3);
            s_redir = ($urandom_range(0, 9) == 0);
            s_rpc   = ($urandom_range(0, 3) == 0) ? 8'(8'hFC | 8'($urandom_range(0, 3)))
                                                  : 8'($urandom);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
